// File: rtl/seq_pattern_pkg.sv
// Shared types for the serial pattern transmitter and its "11" pair counter.
package seq_pattern_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } tx_state_t;

  localparam int unsigned CNT_W_DEFAULT = 8;

  // All-ones value of a w-bit counter, i.e. where a saturating count stops.
  function automatic longint unsigned cnt_max(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/seq11_pair_counter.sv
// Saturating count of overlapping "11" pairs in a stream of valid bits.
// An invalid cycle breaks the chain, so pairs never span a gap.
module seq11_pair_counter
  import seq_pattern_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  logic             prev_q, prev_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    prev_d  = bit_valid & bit_in;
    count_d = count_q;
    if (clear) begin
      prev_d  = 1'b0;
      count_d = '0;
    end else if (bit_valid && bit_in && prev_q && (count_q != CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q  <= 1'b0;
      count_q <= '0;
    end else begin
      prev_q  <= prev_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: loads a pattern over valid/ready, emits it
// MSB-first with optional repeats, and tracks the "11" pairs it sent.
module seq_pattern_tx
  import seq_pattern_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LEN_W = $clog2(WIDTH + 1),
  parameter int REP_W = 4,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_pattern,
  input  logic [LEN_W-1:0] load_len,
  input  logic [REP_W-1:0] load_repeat,
  input  logic             abort,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] exp_count
);

  localparam int POS_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  tx_state_t        state_q, state_d;
  logic [WIDTH-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic             done_q, done_d;
  logic             accept;
  logic [LEN_W-1:0] eff_len;

  // A length of zero, or anything beyond the register, means a full-width frame.
  always_comb begin
    eff_len = load_len;
    if ((load_len == '0) || (load_len > LEN_W'(WIDTH))) begin
      eff_len = LEN_W'(WIDTH);
    end
  end

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    pos_d     = pos_q;
    rep_d     = rep_q;
    done_d    = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_valid) begin
          accept    = 1'b1;
          pattern_d = load_pattern;
          len_d     = eff_len;
          pos_d     = POS_W'(eff_len - 1'b1);
          rep_d     = load_repeat;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (pos_q == '0) begin
          if (rep_q != '0) begin
            rep_d   = rep_q - 1'b1;
            state_d = GAP;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          pos_d = pos_q - 1'b1;
        end
      end
      GAP: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          pos_d   = POS_W'(len_q - 1'b1);
          state_d = SHIFT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pattern_q <= '0;
      len_q     <= '0;
      pos_q     <= '0;
      rep_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      pos_q     <= pos_d;
      rep_q     <= rep_d;
      done_q    <= done_d;
    end
  end

  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign out_valid  = (state_q == SHIFT);
  assign out        = out_valid & pattern_q[pos_q];
  assign done       = done_q;

  seq11_pair_counter #(
    .CNT_W(CNT_W)
  ) u_pairs (
    .clk      (clk),
    .reset    (reset),
    .bit_in   (out),
    .bit_valid(out_valid),
    .clear    (accept),
    .count    (exp_count)
  );

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: a frame-level model predicts every
// emitted bit, its cycle, and each done pulse with its pair count.
module tb_seq_pattern_tx;

  localparam int WIDTH = 16;
  localparam int LEN_W = 5;
  localparam int REP_W = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             load_valid = 1'b0;
  logic             abort = 1'b0;
  logic [WIDTH-1:0] load_pattern = '0;
  logic [LEN_W-1:0] load_len = '0;
  logic [REP_W-1:0] load_repeat = '0;
  logic             load_ready, out, out_valid, busy, done;
  logic [CNT_W-1:0] exp_count;

  seq_pattern_tx #(
    .WIDTH(WIDTH), .LEN_W(LEN_W), .REP_W(REP_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_pattern(load_pattern), .load_len(load_len), .load_repeat(load_repeat),
    .abort(abort), .out(out), .out_valid(out_valid), .busy(busy), .done(done),
    .exp_count(exp_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic b; } bit_exp_t;
  typedef struct { int cyc; int cnt; } done_exp_t;
  bit_exp_t  bq[$];
  done_exp_t dq[$];

  int n_checks = 0;
  int n_pass   = 0;
  int last_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  // Monitor: every presented bit and every done pulse is matched against the queues.
  always @(negedge clk) begin
    bit_exp_t  be;
    done_exp_t de;
    if (out_valid === 1'b1) begin
      n_checks++;
      if (bq.size() == 0) begin
        $display("FAIL unexpected_bit: got bit %0d at cycle %0d, expected none", out, cyc);
      end else begin
        n_pass++;
        be = bq.pop_front();
        chk("bit_cycle", cyc, be.cyc);
        chk("bit_value", out, be.b);
      end
    end else begin
      chk("idle_out_zero", out, 0);
    end
    if (done === 1'b1) begin
      n_checks++;
      if (dq.size() == 0) begin
        $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        n_pass++;
        de = dq.pop_front();
        chk("done_cycle", cyc, de.cyc);
        chk("done_count", exp_count, de.cnt);
      end
    end
  end

  // Presents one job, waits for the handshake, and queues the model's prediction.
  // Returns at the falling edge of the cycle after the handshake with load_valid still high.
  task automatic send(input logic [WIDTH-1:0] pat, input int len, input int rep,
                      input int abort_at, output int t);
    int l, frames, cnt, guard, c;
    load_pattern = pat;
    load_len     = LEN_W'(len);
    load_repeat  = REP_W'(rep);
    load_valid   = 1'b1;
    guard = 0;
    while (load_ready !== 1'b1 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    chk("accept_in_time", (guard < 1000), 1);
    if (guard >= 1000) begin
      t = -1;
      return;
    end
    t      = cyc;
    l      = (len == 0 || len > WIDTH) ? WIDTH : len;
    frames = rep + 1;
    cnt    = 0;
    for (int f = 0; f < frames; f++) begin
      for (int k = 0; k < l; k++) begin
        c = t + 1 + f * (l + 1) + k;
        if (abort_at == 0 || c <= t + abort_at) begin
          bq.push_back('{cyc: c, b: pat[l-1-k]});
          if (k > 0 && pat[l-k] && pat[l-1-k]) cnt++;
        end
      end
    end
    if (cnt > CMAX) cnt = CMAX;
    last_cnt = cnt;
    if (abort_at == 0) dq.push_back('{cyc: t + frames * (l + 1), cnt: cnt});
    $display("job t=%0d pattern=%h len=%0d repeat=%0d abort_at=%0d expected_pairs=%0d",
             t, pat, len, rep, abort_at, cnt);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy !== 1'b0 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    chk("idle_in_time", (g < 2000), 1);
  endtask

  task automatic run_job(input logic [WIDTH-1:0] pat, input int len, input int rep,
                         input int abort_at);
    int t;
    send(pat, len, rep, abort_at, t);
    load_valid = 1'b0;
    abort      = 1'b0;
    if (t < 0) return;
    if (abort_at > 0) begin
      repeat (abort_at - 1) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_ready", load_ready, 1);
      chk("abort_out", out, 0);
      chk("abort_no_done", done, 0);
      chk("abort_count", exp_count, last_cnt);
    end else begin
      wait_idle();
    end
    @(negedge clk);
    chk("idle_count_hold", exp_count, last_cnt);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected to finish", cyc);
    $fatal(1);
  end

  initial begin
    int t1, t2, l, r, a;
    logic [WIDTH-1:0] p;

    // Reset held with a pending job: nothing may be accepted.
    reset = 1'b1;
    load_valid = 1'b1;
    load_pattern = 16'hFFFF;
    load_len = '0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", load_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_out", out, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_count", exp_count, 0);
    end
    reset = 1'b0;
    load_valid = 1'b0;
    @(negedge clk);

    run_job(16'h00B6, 8, 0, 0);
    chk("b6_pairs", exp_count, 2);
    run_job(16'h000F, 4, 1, 0);
    chk("f_rep_pairs", exp_count, 6);
    run_job(16'h00FF, 8, 0, 3);
    chk("abort_pairs", exp_count, 2);
    run_job(16'hFFFF, 0, 15, 0);
    chk("sat_pairs", exp_count, CMAX);

    // load_valid held across two jobs: the second is taken on the first's done cycle.
    send(16'h0003, 2, 0, 0, t1);
    send(16'h0003, 2, 0, 0, t2);
    load_valid = 1'b0;
    wait_idle();
    chk("b2b_spacing", t2 - t1, 3);

    // abort together with load_valid in IDLE still accepts the job.
    abort = 1'b1;
    run_job(16'h1B3D, 14, 1, 0);

    // Reset in the middle of a job drops it silently.
    send(16'hAAAA, 16, 2, 0, t1);
    load_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    bq.delete();
    dq.delete();
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_count", exp_count, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      p = WIDTH'($urandom);
      l = $urandom_range(0, 20);
      r = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 2);
      a = 0;
      if ($urandom_range(0, 3) == 0) begin
        a = $urandom_range(1, (r + 1) * (((l == 0 || l > WIDTH) ? WIDTH : l) + 1) - 1);
      end
      run_job(p, l, r, a);
    end

    repeat (2) @(negedge clk);
    chk("bits_drained", bq.size(), 0);
    chk("dones_drained", dq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
